div_unit: RTL and testbench

Multicycle signed 32-bit divider for the MIPS multicycle CPU datapath, the sibling of the mult block. It consumes the A and B register outputs and produces HI (remainder) and LO (quotient) for mfhi/mflo. The control unit starts it with div_control and waits for div_end. It also reports divide-by-zero, which drives the control unit's exception path (EPC / exception-vector address mux).

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle divider (div_unit, div_step).
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    FIX
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, try subtracting the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]          rem_sh;
  logic [WIDTH-1:0]        quo_sh;
  logic signed [WIDTH+1:0] trial;

  always_comb begin
    rem_sh = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    quo_sh = {quo_in[WIDTH-2:0], 1'b0};
    trial  = signed'({1'b0, rem_sh}) - signed'({2'b00, divisor});
    if (trial >= 0) begin
      rem_out = trial[WIDTH:0];
      quo_out = {quo_sh[WIDTH-1:1], 1'b1};
    end else begin
      rem_out = rem_sh;
      quo_out = quo_sh;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider: HI = remainder, LO = quotient, WIDTH+3 cycles per divide.
// Optional DIV_UNSIGNED_EN adds a div_unsigned input selecting divu behaviour.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             div_control,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_end,
  output logic             div_zero
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? ('0 - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  div_state_t state_q, state_d;
  logic       end_d, zero_d;

  logic signed [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]          rem_q, rem_nxt;
  logic [WIDTH-1:0]        quo_q, quo_nxt;
  logic [WIDTH-1:0]        dvs_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    qneg_q, rneg_q;
  logic                    sgn_op;

`ifdef DIV_UNSIGNED_EN
  logic uns_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uns_q <= 1'b0;
    end else if (state_q == IDLE && div_control) begin
      uns_q <= div_unsigned;
    end
  end

  assign sgn_op = ~uns_q;
`else
  assign sgn_op = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_end  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_end  <= end_d;
      div_zero <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    end_d   = 1'b0;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_control) begin
          if (b_in == '0) begin
            end_d  = 1'b1;
            zero_d = 1'b1;
          end else begin
            state_d = INIT;
          end
        end
      end
      INIT: state_d = RUN;
      RUN: begin
        if (cnt_q == LAST_CNT) state_d = FIX;
      end
      FIX: begin
        end_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(dvs_q),
    .rem_out(rem_nxt),
    .quo_out(quo_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state_q)
        // Capture: operands are frozen here, later input changes are ignored
        IDLE: begin
          if (div_control) begin
            a_q <= a_in;
            b_q <= b_in;
          end
        end
        // Magnitude setup: the restoring loop works on unsigned magnitudes
        INIT: begin
          quo_q  <= sgn_op ? mag(a_q) : a_q;
          dvs_q  <= sgn_op ? mag(b_q) : b_q;
          rem_q  <= '0;
          cnt_q  <= '0;
          qneg_q <= sgn_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_q <= sgn_op & a_q[WIDTH-1];
        end
        RUN: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        // Sign fixup: truncation toward zero, remainder follows the dividend
        FIX: begin
          lo_out <= cond_neg(quo_q, qneg_q);
          hi_out <= cond_neg(rem_q[WIDTH-1:0], rneg_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed corner cases, divide-by-zero, reset abort, restart.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        div_control = 1'b0;
`ifdef DIV_UNSIGNED_EN
  logic        div_unsigned = 1'b0;
`endif
  logic [31:0] hi_out, lo_out;
  logic        div_end, div_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_in       (a_in),
    .b_in       (b_in),
    .div_control(div_control),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned(div_unsigned),
`endif
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .div_end    (div_end),
    .div_zero   (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns #1 after edge 0 (the sampling edge) with div_control already dropped.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    a_in        = a;
    b_in        = b;
    div_control = 1'b1;
    @(posedge clk);
    #1;
    div_control = 1'b0;
  endtask

  task automatic wait_done(output int first_edge, output int pulses, output logic zflag,
                           output int stray_zero);
    first_edge = -1;
    pulses     = 0;
    zflag      = 1'b0;
    stray_zero = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (div_end) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = e;
          zflag      = div_zero;
        end
      end else if (div_zero) begin
        stray_zero++;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int   first_edge, pulses, stray;
    logic zflag;
    start_op(a, b);
    wait_done(first_edge, pulses, zflag, stray);
    check({tag, "_end_edge"}, first_edge, 34);
    check({tag, "_end_pulses"}, pulses, 1);
    check({tag, "_zero"}, {31'd0, zflag}, 32'd0);
    check({tag, "_stray_zero"}, stray, 0);
    check({tag, "_lo"}, lo_out, exp_lo);
    check({tag, "_hi"}, hi_out, exp_hi);
  endtask

  initial begin
    int   ends, first_e, second_e;
    logic [31:0] lo1, hi1;

    #1;
    check("rst_lo", lo_out, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_end", {31'd0, div_end}, 32'd0);
    check("rst_zero", {31'd0, div_zero}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_div("p7d2", 32'd7, 32'd2, 32'd3, 32'd1);

    start_op(32'd5, 32'd0);
    check("dz_end", {31'd0, div_end}, 32'd1);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_lo_kept", lo_out, 32'd3);
    check("dz_hi_kept", hi_out, 32'd1);
    @(posedge clk);
    #1;
    check("dz_end_drop", {31'd0, div_end}, 32'd0);
    check("dz_flag_drop", {31'd0, div_zero}, 32'd0);

    run_div("m7d2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("p7dm2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("p3d10", 32'd3, 32'd10, 32'd0, 32'd3);
    run_div("max_d16", 32'h7FFF_FFFF, 32'd16, 32'h07FF_FFFF, 32'd15);

    // Reset abort partway through a divide
    start_op(32'd100, 32'd7);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    check("abort_lo", lo_out, 32'd0);
    check("abort_hi", hi_out, 32'd0);
    check("abort_end", {31'd0, div_end}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ends = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (div_end) ends++;
    end
    check("abort_no_end", ends, 0);
    run_div("p100d7", 32'd100, 32'd7, 32'd14, 32'd2);

    // div_control held high: one run, then a restart sampled in the div_end cycle
    @(posedge clk);
    #1;
    a_in        = 32'hFFFF_FF9C;
    b_in        = 32'd7;
    div_control = 1'b1;
    @(posedge clk);
    #1;
    ends     = 0;
    first_e  = -1;
    second_e = -1;
    lo1      = '0;
    hi1      = '0;
    for (int e = 1; e <= 75; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) begin
        a_in = 32'd9;
        b_in = 32'd4;
      end
      if (e == 35) div_control = 1'b0;
      if (div_end) begin
        ends++;
        if (first_e < 0) begin
          first_e = e;
          lo1     = lo_out;
          hi1     = hi_out;
        end else if (second_e < 0) begin
          second_e = e;
        end
      end
    end
    check("hold_pulses", ends, 2);
    check("hold_first_edge", first_e, 34);
    check("hold_second_edge", second_e, 69);
    check("hold_first_lo", lo1, 32'hFFFF_FFF2);
    check("hold_first_hi", hi1, 32'hFFFF_FFFE);
    check("hold_second_lo", lo_out, 32'd2);
    check("hold_second_hi", hi_out, 32'd1);

`ifdef DIV_UNSIGNED_EN
    div_unsigned = 1'b1;
    run_div("divu", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
    div_unsigned = 1'b0;
    run_div("div_signed_after_u", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
